// File: rtl/fetch_sequencer_pkg.sv
// Shared sequencer types and default program-map constants, also used by the ROM and the top level.
// Pure declarations: no logic, no latency, no flow control.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int AW_DEF         = 11;
  localparam int PROG0_BASE_DEF = 0;
  localparam int PROG1_BASE_DEF = 256;
  localparam int PROG2_BASE_DEF = 512;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; output registered, one cycle per count.
// Clear beats enable; the count sticks at all-ones and never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter / run-control FSM for the instruction ROM; all outputs registered, one-cycle PC update.
// Decoder controls act at the next edge; Start is ignored while a program is running.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int CW         = 16,
  parameter int PROG0_BASE = PROG0_BASE_DEF,
  parameter int PROG1_BASE = PROG1_BASE_DEF,
  parameter int PROG2_BASE = PROG2_BASE_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          BranchAbs,
  input  logic          BranchRel,
  input  logic [AW-1:0] Target,
  output logic [AW-1:0] InstAddress,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  seq_state_t    r_state;
  logic [AW-1:0] r_pc;
  logic          r_running;
  logic          r_done;

  logic [AW-1:0] w_base;
  logic          w_start_acc;
  logic          w_cnt_clr;
  logic          w_cnt_en;

  always_comb begin
    case (ProgSel)
      2'd1:    w_base = AW'(PROG1_BASE);
      2'd2:    w_base = AW'(PROG2_BASE);
      default: w_base = AW'(PROG0_BASE);
    endcase
  end

  assign w_start_acc = Start && (r_state != ST_RUN);
  assign w_cnt_clr   = Reset || w_start_acc;
  assign w_cnt_en    = (r_state == ST_RUN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            r_state   <= ST_RUN;
            r_pc      <= w_base;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        ST_RUN: begin
          // Halt leaves the PC parked on the halt instruction itself.
          if (Halt) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (Stall) begin
            r_pc <= r_pc;
          end else if (BranchAbs) begin
            r_pc <= Target;
          end else if (BranchRel) begin
            r_pc <= r_pc + Target;
          end else begin
            r_pc <= r_pc + AW'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CW)
  ) u_cycle_cnt (
    .i_clk   (Clk),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (CycleCount)
  );

  assign InstAddress = r_pc;
  assign Running     = r_running;
  assign Done        = r_done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer, with a narrow-counter copy sharing the same stimulus.
module tb_fetch_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Halt;
  logic        Stall;
  logic        BranchAbs;
  logic        BranchRel;
  logic [10:0] Target;
  logic [10:0] InstAddress;
  logic        Running;
  logic        Done;
  logic [15:0] CycleCount;
  logic [10:0] s_InstAddress;
  logic        s_Running;
  logic        s_Done;
  logic [3:0]  s_CycleCount;

  int n_err;
  int n_checks;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .Halt(Halt), .Stall(Stall), .BranchAbs(BranchAbs), .BranchRel(BranchRel),
    .Target(Target), .InstAddress(InstAddress), .Running(Running),
    .Done(Done), .CycleCount(CycleCount)
  );

  fetch_sequencer #(.CW(4)) dut_small (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .Halt(Halt), .Stall(Stall), .BranchAbs(BranchAbs), .BranchRel(BranchRel),
    .Target(Target), .InstAddress(s_InstAddress), .Running(s_Running),
    .Done(s_Done), .CycleCount(s_CycleCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int ia, input int run, input int dn, input int cc);
    chk({tag, ".addr"}, 32'(InstAddress), 32'(ia));
    chk({tag, ".running"}, 32'(Running), 32'(run));
    chk({tag, ".done"}, 32'(Done), 32'(dn));
    chk({tag, ".count"}, 32'(CycleCount), 32'(cc));
  endtask

  initial begin
    n_err = 0; n_checks = 0;
    Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; Halt = 1'b0; Stall = 1'b0;
    BranchAbs = 1'b0; BranchRel = 1'b0; Target = '0;
    tick();
    tick();
    chk_state("reset", 0, 0, 0, 0);

    Reset = 1'b0; Start = 1'b1; ProgSel = 2'd1;
    tick();
    Start = 1'b0;
    chk_state("start_p1", 256, 1, 0, 0);
    repeat (10) tick();
    chk_state("ten_steps", 266, 1, 0, 10);
    chk("small.count10", 32'(s_CycleCount), 32'd10);

    Start = 1'b1; ProgSel = 2'd2;
    tick();
    Start = 1'b0;
    chk_state("start_in_run", 267, 1, 0, 11);

    BranchAbs = 1'b1; Target = 11'd300;
    tick();
    BranchAbs = 1'b0; BranchRel = 1'b1; Target = 11'h7FC;
    chk("abs300", 32'(InstAddress), 32'd300);
    tick();
    chk("rel_minus4", 32'(InstAddress), 32'd296);
    BranchAbs = 1'b1; Target = 11'd5;
    tick();
    chk("abs_over_rel", 32'(InstAddress), 32'd5);
    BranchRel = 1'b0; Target = 11'd2047;
    tick();
    BranchAbs = 1'b0;
    chk("abs2047", 32'(InstAddress), 32'd2047);
    tick();
    chk_state("wrap", 0, 1, 0, 16);

    BranchAbs = 1'b1; Target = 11'd40;
    tick();
    Stall = 1'b1; Target = 11'd99;
    repeat (3) tick();
    Stall = 1'b0; BranchAbs = 1'b0;
    chk_state("stall3", 40, 1, 0, 20);
    chk("small.sat20", 32'(s_CycleCount), 32'd15);

    BranchAbs = 1'b1; Target = 11'd600;
    tick();
    BranchAbs = 1'b0; Halt = 1'b1; Stall = 1'b1;
    tick();
    Halt = 1'b0; Stall = 1'b0;
    chk_state("halt600", 600, 0, 1, 22);
    chk("small.sat22", 32'(s_CycleCount), 32'd15);

    Halt = 1'b1; BranchAbs = 1'b1; Target = 11'd7;
    tick();
    Halt = 1'b0; BranchAbs = 1'b0;
    chk_state("done_hold", 600, 0, 1, 22);

    Start = 1'b1; ProgSel = 2'd3;
    tick();
    Start = 1'b0;
    chk_state("restart_sel3", 0, 1, 0, 0);
    chk("small.restart", 32'(s_CycleCount), 32'd0);
    repeat (2) tick();
    chk_state("restart_step", 2, 1, 0, 2);

    Reset = 1'b1; Start = 1'b1; ProgSel = 2'd2;
    tick();
    Reset = 1'b0; Start = 1'b0;
    chk_state("reset_midrun", 0, 0, 0, 0);
    BranchAbs = 1'b1; Target = 11'd77;
    tick();
    BranchAbs = 1'b0;
    chk_state("idle_ignore", 0, 0, 0, 0);

    Start = 1'b1; ProgSel = 2'd2;
    tick();
    Start = 1'b0;
    chk_state("start_p2", 512, 1, 0, 0);
    tick();
    chk_state("p2_step", 513, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-sequencing controller for the 2048-entry, 9-bit instruction ROM. It owns the program counter that drives the ROM address and starts one of three resident programs on a Start/Done handshake. It steps, stalls or branches the PC under control of the decoder, and stops on Halt. It sits between the top-level test harness (Start/ProgSel/Done) and the ROM/decoder pair.

## Interface
- AW, 11: instruction address width (ROM depth 2**AW)
- CW, 16: cycle-counter width
- PROG0_BASE, 0: start address of program 0
- PROG1_BASE, 256: start address of program 1
- PROG2_BASE, 512: start address of program 2

Clocking and reset are fixed: one clock, Clk; Reset is synchronous and active-high.

- Clk  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high; highest priority
- Start  in  1  request to launch the program selected by ProgSel
- ProgSel  in  2  program select; 0/1/2 select PROGn_BASE, 3 maps to PROG0_BASE
- Halt  in  1  decoder: instruction at InstAddress is halt
- Stall  in  1  hold PC this cycle
- BranchAbs  in  1  take absolute branch to Target
- BranchRel  in  1  take relative branch, PC + signed Target
- Target  in  AW  absolute address, or two's-complement offset
- InstAddress  out  AW  registered PC, drives ROM address
- Running  out  1  high while in RUN; InstAddress is a live fetch
- Done  out  1  high in DONE until next accepted Start
- CycleCount  out  CW  RUN cycles since last accepted Start, saturating

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Reset, regardless of state: IDLE, InstAddress=0, Running=0, Done=0, CycleCount=0.
- IDLE: PC holds. Start=1 → RUN, InstAddress←base(ProgSel), CycleCount←0.
- RUN:
  - Each cycle CycleCount increments, saturating at 2**CW-1.
  - PC update priority: Halt > Stall > BranchAbs > BranchRel > increment.
  - Halt: → DONE, PC holds on the halt instruction.
  - Stall: PC holds.
  - BranchAbs: PC←Target.
  - BranchRel: PC←(PC + Target) mod 2**AW. Target is treated as signed AW-bit.
  - Else: PC←(PC+1) mod 2**AW. 2**AW-1 wraps to 0.
  - Start in RUN is ignored. ProgSel is not sampled.
- DONE:
  - Done=1, Running=0; PC and CycleCount hold.
  - Start=1 → RUN with the new base. Done drops the same edge, CycleCount←0.
- BranchAbs and BranchRel both high: BranchAbs wins.
- Control inputs (Halt/Stall/Branch*) are ignored outside RUN.
- Running=1 exactly when state=RUN. Done=1 exactly when state=DONE.

## Timing
- The ROM read is combinational, so the instruction at InstAddress is valid in the same cycle. Halt/Stall/Branch* refer to that instruction and take effect at the next rising edge.
- Start accepted at edge N:
  - first fetch address is visible after edge N;
  - Running=1 from edge N;
  - CycleCount=0 after edge N, 1 after edge N+1.
- Halt seen at edge M: Running=0 and Done=1 after edge M. The halt cycle is counted.
- Branch latency is one cycle: no delay slot and no wrong-path fetch beyond the branch instruction itself.
- Reset asserted mid-RUN: at that edge the block returns to reset values, and a Start sampled in the same cycle is discarded. Start must be re-asserted after Reset deasserts.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package holds:
  - the state enum {IDLE, RUN, DONE};
  - the AW default (11) and default base-address constants, shared with the ROM and the top level.
- Natural sub-module: sat_counter (CW-bit, synchronous clear, enable, saturate). It is used for CycleCount.
- The PC next-state mux stays inline in fetch_sequencer.

## Test plan
- Reset, then Start with ProgSel=1 at edge 2 → InstAddress=256, Running=1. Ten idle cycles → InstAddress=266, CycleCount=10.
- RUN at PC=300, BranchRel with Target=11'h7FC (−4) → PC=296. Then BranchAbs with Target=5 and BranchRel both high → PC=5.
- PC=2047 with no control → PC=0 (wrap). Stall held 3 cycles at PC=40 → PC stays 40, CycleCount still advances by 3.
- Halt at PC=600 → next cycle Done=1, Running=0, InstAddress=600. Start in RUN earlier in the run had no effect. Start with ProgSel=3 → InstAddress=0, Done=0, CycleCount=0.
- Reset asserted mid-RUN together with Start → IDLE, all outputs 0. Start one cycle later with ProgSel=2 → InstAddress=512.
- Force CW=4 and run 20 cycles → CycleCount holds at 15.
